// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline-control unit.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int STG_IF_ID   = 0;
  localparam int STG_ID_EX   = 1;
  localparam int STG_EX_MEM  = 2;
  localparam int STG_MEM_WB  = 3;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // count up on inc, hold once saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (inc && (q != {WIDTH{1'b1}}))
      q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/pipe_ctrl_multi.sv
// Pipeline control: stall merge, load-use bubble, stall-aware flush sequencer.
//
//   state | meaning
//   IDLE  | normal flow; load-use holds honoured
//   FLUSH | squashing FLUSH_MASK stages for fcnt more advancing cycles
module pipe_ctrl_multi
  import pipe_ctrl_pkg::*;
#(
  parameter int                    NUM_STAGES = 4,
  parameter int                    NUM_STALL  = 2,
  parameter int                    FLUSH_LEN  = 2,
  parameter logic [NUM_STAGES-1:0] FLUSH_MASK = 4'b0001,
  parameter int                    HAZ_STAGE  = STG_ID_EX,
  parameter int                    CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STALL-1:0]  stall_req,
  input  logic                  hazard_hold,
  input  logic                  flush_req,
  output logic                  pc_load,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic                  flush_busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  generate
    if (FLUSH_LEN < 1 || FLUSH_LEN > 15) begin : g_bad_flush_len
      $error("pipe_ctrl_multi: FLUSH_LEN must be 1..15");
    end
    if (HAZ_STAGE >= NUM_STAGES) begin : g_bad_haz_stage
      $error("pipe_ctrl_multi: HAZ_STAGE must be below NUM_STAGES");
    end
    if (NUM_STALL < 1) begin : g_bad_num_stall
      $error("pipe_ctrl_multi: NUM_STALL must be at least 1");
    end
  endgenerate

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_LEN);

  state_t                 state, state_nxt;
  logic [FLUSH_CNT_W-1:0] fcnt, fcnt_nxt;
  logic                   frozen;
  logic                   advance;
  logic                   haz_active;

  assign frozen  = |stall_req;
  assign advance = !frozen;

  // A hold is pointless when the instruction is being squashed anyway.
  assign haz_active = (state == IDLE) && !flush_req && advance && hazard_hold;

  // state and flush down-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // next state: redirects are taken even when frozen; reload beats decrement
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          fcnt_nxt = FLUSH_LOAD;
        end else if (advance) begin
          fcnt_nxt = fcnt - FLUSH_CNT_W'(1);
          if (fcnt == FLUSH_CNT_W'(1))
            state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

  // load/flush outputs: freeze gates loads, flush mask persists while frozen
  always_comb begin
    pc_load     = 1'b1;
    stage_load  = '1;
    stage_flush = '0;
    if (state == FLUSH)
      stage_flush = FLUSH_MASK;
    if (frozen) begin
      pc_load    = 1'b0;
      stage_load = '0;
    end else if (haz_active) begin
      pc_load = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i < HAZ_STAGE)
          stage_load[i] = 1'b0;
      end
      stage_flush[HAZ_STAGE] = 1'b1;
    end
  end

  assign flush_busy = (state == FLUSH);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frozen),
    .q   (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_req),
    .q   (flush_events)
  );

endmodule

// File: tb/tb_pipe_ctrl_multi.sv
// Bench for pipe_ctrl_multi: directed scenarios plus random traffic against
// a cycle-level reference model. A second instance with 4-bit counters
// exercises saturation on the same stimulus.
module tb_pipe_ctrl_multi;

  localparam int         FLUSH_LEN  = 2;
  localparam logic [3:0] FLUSH_MASK = 4'b0001;
  localparam int         HAZ_STAGE  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] stall_req;
  logic       hazard_hold;
  logic       flush_req;

  logic        pc_load, flush_busy;
  logic [3:0]  stage_load, stage_flush;
  logic [15:0] stall_cycles, flush_events;

  logic        s_pc_load, s_flush_busy;
  logic [3:0]  s_stage_load, s_stage_flush;
  logic [3:0]  s_stall_cycles, s_flush_events;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: flush cycles still owed, and raw event tallies
  int rem_flush;
  int n_stall;
  int n_flush;
  int busy_seen;

  always #5 clk = ~clk;

  pipe_ctrl_multi dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .hazard_hold  (hazard_hold),
    .flush_req    (flush_req),
    .pc_load      (pc_load),
    .stage_load   (stage_load),
    .stage_flush  (stage_flush),
    .flush_busy   (flush_busy),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  pipe_ctrl_multi #(.CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .hazard_hold  (hazard_hold),
    .flush_req    (flush_req),
    .pc_load      (s_pc_load),
    .stage_load   (s_stage_load),
    .stage_flush  (s_stage_flush),
    .flush_busy   (s_flush_busy),
    .stall_cycles (s_stall_cycles),
    .flush_events (s_flush_events)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_outputs();
    logic       frz, hold;
    logic [3:0] e_load, e_flush;
    logic       e_pc;
    frz  = |stall_req;
    hold = (rem_flush == 0) && !flush_req && !frz && hazard_hold;
    e_pc    = !frz && !hold;
    e_load  = frz ? 4'b0000 : (hold ? 4'((16 - (1 << HAZ_STAGE)) & 15) : 4'b1111);
    e_flush = (rem_flush > 0) ? FLUSH_MASK : (hold ? 4'(1 << HAZ_STAGE) : 4'b0000);
    check("pc_load",      {31'd0, pc_load},      {31'd0, e_pc});
    check("stage_load",   {28'd0, stage_load},   {28'd0, e_load});
    check("stage_flush",  {28'd0, stage_flush},  {28'd0, e_flush});
    check("flush_busy",   {31'd0, flush_busy},   (rem_flush > 0) ? 32'd1 : 32'd0);
    check("stall_cycles", {16'd0, stall_cycles}, 32'(sat(n_stall, 16)));
    check("flush_events", {16'd0, flush_events}, 32'(sat(n_flush, 16)));
    check("sat_stall",    {28'd0, s_stall_cycles}, 32'(sat(n_stall, 4)));
    check("sat_flush",    {28'd0, s_flush_events}, 32'(sat(n_flush, 4)));
  endtask

  // one clock cycle: drive, check mid-cycle, update model at the edge
  task automatic step(input logic [1:0] s, input logic h, input logic f);
    stall_req   = s;
    hazard_hold = h;
    flush_req   = f;
    @(negedge clk);
    check_outputs();
    if (flush_busy) busy_seen++;
    @(posedge clk);
    if (f) begin
      rem_flush = FLUSH_LEN;
      n_flush++;
    end else if (s == 2'b00 && rem_flush > 0) begin
      rem_flush--;
    end
    if (s != 2'b00) n_stall++;
    #1;
  endtask

  task automatic do_reset();
    stall_req   = 2'b00;
    hazard_hold = 1'b0;
    flush_req   = 1'b0;
    rst = 1'b1;
    rem_flush = 0;
    n_stall   = 0;
    n_flush   = 0;
    #1;
    check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
    check("rst_stage_flush", {28'd0, stage_flush}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    stall_req   = 2'b00;
    hazard_hold = 1'b0;
    flush_req   = 1'b0;
    busy_seen   = 0;
    #12;
    do_reset();

    // reset then idle
    idle_cycles(3);
    check("idle_pc_load", {31'd0, pc_load}, 32'd1);

    // plain flush: two busy cycles
    busy_seen = 0;
    step(2'b00, 1'b0, 1'b1);
    idle_cycles(4);
    check("plain_flush_len", busy_seen, 32'd2);
    check("plain_flush_events", {16'd0, flush_events}, 32'd1);

    // flush across a 3-cycle stall: five busy cycles
    busy_seen = 0;
    step(2'b00, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    idle_cycles(4);
    check("stalled_flush_len", busy_seen, 32'd5);
    check("stalled_stall_cycles", {16'd0, stall_cycles}, 32'd3);

    // back-to-back redirects: three busy cycles
    busy_seen = 0;
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    idle_cycles(4);
    check("reflush_len", busy_seen, 32'd3);
    check("reflush_events", {16'd0, flush_events}, 32'd4);

    // load-use hold alone, then together with a redirect
    hazard_hold = 1'b1;
    #1;
    check("haz_stage_load", {28'd0, stage_load}, 32'h0000_000E);
    check("haz_stage_flush", {28'd0, stage_flush}, 32'h0000_0002);
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1);
    check("haz_flush_busy", {31'd0, flush_busy}, 32'd1);
    step(2'b00, 1'b1, 1'b0);
    idle_cycles(3);

    // asynchronous reset in the middle of a flush
    step(2'b00, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midflush_rst_busy", {31'd0, flush_busy}, 32'd0);
    check("midflush_rst_flush", {28'd0, stage_flush}, 32'd0);
    check("midflush_rst_cnt", {16'd0, flush_events}, 32'd0);
    do_reset();

    // saturation of the 4-bit instance
    for (int i = 0; i < 20; i++) step(2'b01, 1'b0, 1'b0);
    idle_cycles(1);
    check("sat_stall_15", {28'd0, s_stall_cycles}, 32'd15);
    check("wide_stall_20", {16'd0, stall_cycles}, 32'd20);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 199) == 0)
        do_reset();
      else
        step(s, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
